// File: rtl/delay_line_manager.sv
// Recirculating delay-line memory manager: pulse-slot timing, zero-latency recirculation,
// queued word replacement, golden-copy checking and a report FIFO for the message layer.
module delay_line_manager #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 6,
  parameter int PW_WIDTH      = 8,
  parameter int GAP_WIDTH     = 8,
  parameter int REPORT_DEPTH  = 4,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     run,
  input  logic                     in,
  output logic                     out,
  input  logic [ADDR_WIDTH-1:0]    no_nums,
  input  logic [PW_WIDTH-1:0]      pulse_width,
  input  logic [GAP_WIDTH-1:0]     pulse_gap,
  input  logic                     test_mode,
  input  logic [ADDR_WIDTH-1:0]    rep_addr,
  input  logic [DATA_WIDTH-1:0]    rep_data,
  input  logic                     rep_valid,
  output logic                     rep_ready,
  output logic [ADDR_WIDTH-1:0]    rpt_addr,
  output logic [DATA_WIDTH-1:0]    rpt_data,
  output logic                     rpt_replaced,
  output logic                     rpt_valid,
  input  logic                     rpt_ready,
  output logic                     rpt_overrun,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-1:0]    word_addr
);

  localparam int NW = 1 << ADDR_WIDTH;
  localparam int CW = ((PW_WIDTH > GAP_WIDTH) ? PW_WIDTH : GAP_WIDTH) + 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int FW = $clog2(REPORT_DEPTH);
  localparam int EW = ADDR_WIDTH + DATA_WIDTH + 1;

  logic [CW-1:0]         ctr_r, period_s, sample_pt_s;
  logic [BW-1:0]         bit_r;
  logic [ADDR_WIDTH-1:0] word_r, next_word_s;
  logic [ADDR_WIDTH:0]   n_words_s;
  logic                  active_s, slot_end_s, pulse_s, sample_s, last_bit_s, load_s, accept_s;
  logic [NW-1:0]         pending_r, gvalid_r;
  logic [DATA_WIDTH-1:0] repl_mem [NW];
  logic [DATA_WIDTH-1:0] golden_mem [NW];
  logic [DATA_WIDTH-1:0] tx_r, rx_r, sample_word_s;
  logic                  replacing_r, mismatch_s, push_s, pop_s, full_s, push_ok_s;
  logic [EW-1:0]         fifo_mem [REPORT_DEPTH];
  logic [FW-1:0]         wr_ptr_r, rd_ptr_r;
  logic [FW:0]           count_r;
  logic [ERR_CNT_WIDTH-1:0] err_r;
  logic                  overrun_r;

  // Slot decode, word wrap and report/replacement handshakes
  always_comb begin
    period_s    = CW'(pulse_gap) + CW'(pulse_width);
    sample_pt_s = CW'(pulse_gap) + CW'(pulse_width >> 1);
    active_s    = run & (pulse_width != {PW_WIDTH{1'b0}});
    slot_end_s  = active_s & (ctr_r >= period_s - CW'(1));
    pulse_s     = active_s & (ctr_r >= CW'(pulse_gap));
    sample_s    = active_s & (ctr_r == sample_pt_s);
    last_bit_s  = (bit_r == BW'(DATA_WIDTH - 1));
    load_s      = slot_end_s & last_bit_s;
    n_words_s   = (no_nums == {ADDR_WIDTH{1'b0}}) ? (ADDR_WIDTH+1)'(NW) : {1'b0, no_nums};
    // ">=" rather than "==" so a shrinking no_nums pulls the counter back at the next wrap check
    next_word_s = ({1'b0, word_r} >= n_words_s - (ADDR_WIDTH+1)'(1)) ?
                  {ADDR_WIDTH{1'b0}} : word_r + ADDR_WIDTH'(1);
    // With pulse_width 1 the sample point is the slot end, so fold in the live sample
    sample_word_s = sample_s ? {rx_r[DATA_WIDTH-2:0], in} : rx_r;
    mismatch_s  = load_s & test_mode & gvalid_r[word_r] & (sample_word_s != golden_mem[word_r]);
    push_s      = load_s & (mismatch_s | replacing_r);
    pop_s       = rpt_ready & (count_r != {(FW+1){1'b0}});
    full_s      = (count_r == (FW+1)'(REPORT_DEPTH));
    push_ok_s   = push_s & (~full_s | pop_s);
    accept_s    = rep_valid & ~load_s;
  end

  assign rep_ready   = ~load_s;
  assign out         = pulse_s & (replacing_r ? tx_r[DATA_WIDTH-1] : in);
  assign word_addr   = word_r;
  assign rpt_valid   = (count_r != {(FW+1){1'b0}});
  assign {rpt_addr, rpt_data, rpt_replaced} = fifo_mem[rd_ptr_r];
  assign rpt_overrun = overrun_r;
  assign err_count   = err_r;

  // Slot, bit and word counters
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ctr_r  <= {CW{1'b0}};
      bit_r  <= {BW{1'b0}};
      word_r <= {ADDR_WIDTH{1'b0}};
    end else if (!run || pulse_width == {PW_WIDTH{1'b0}}) begin
      ctr_r  <= {CW{1'b0}};
      bit_r  <= run ? bit_r : {BW{1'b0}};
      word_r <= run ? word_r : {ADDR_WIDTH{1'b0}};
    end else if (slot_end_s) begin
      ctr_r  <= {CW{1'b0}};
      bit_r  <= last_bit_s ? {BW{1'b0}} : bit_r + BW'(1);
      word_r <= last_bit_s ? next_word_s : word_r;
    end else begin
      ctr_r  <= ctr_r + CW'(1);
    end
  end

  // Pending/golden flags, line shift registers and mismatch counter
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pending_r   <= {NW{1'b0}};
      gvalid_r    <= {NW{1'b0}};
      replacing_r <= 1'b0;
      tx_r        <= {DATA_WIDTH{1'b0}};
      rx_r        <= {DATA_WIDTH{1'b0}};
      err_r       <= {ERR_CNT_WIDTH{1'b0}};
    end else if (!run) begin
      pending_r   <= {NW{1'b0}};
      gvalid_r    <= {NW{1'b0}};
      replacing_r <= 1'b0;
      tx_r        <= {DATA_WIDTH{1'b0}};
      rx_r        <= {DATA_WIDTH{1'b0}};
      err_r       <= {ERR_CNT_WIDTH{1'b0}};
    end else begin
      if (accept_s) begin
        pending_r[rep_addr] <= 1'b1;
        gvalid_r[rep_addr]  <= 1'b1;
      end
      if (load_s) begin
        replacing_r <= pending_r[next_word_s];
        pending_r[next_word_s] <= 1'b0;
        tx_r <= pending_r[next_word_s] ? repl_mem[next_word_s] : tx_r;
      end else if (slot_end_s) begin
        tx_r <= {tx_r[DATA_WIDTH-2:0], 1'b0};
      end
      if (sample_s) begin
        rx_r <= {rx_r[DATA_WIDTH-2:0], in};
      end
      if (mismatch_s && err_r != {ERR_CNT_WIDTH{1'b1}}) begin
        err_r <= err_r + ERR_CNT_WIDTH'(1);
      end
    end
  end

  // Replacement, golden and report storage (not cleared by reset)
  always_ff @(posedge clk) begin
    if (accept_s) begin
      repl_mem[rep_addr]   <= rep_data;
      golden_mem[rep_addr] <= rep_data;
    end
    if (run && push_ok_s) begin
      fifo_mem[wr_ptr_r] <= {word_r, sample_word_s, replacing_r};
    end
  end

  // Report FIFO pointers, occupancy and sticky overrun
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_r  <= {FW{1'b0}};
      rd_ptr_r  <= {FW{1'b0}};
      count_r   <= {(FW+1){1'b0}};
      overrun_r <= 1'b0;
    end else if (!run) begin
      wr_ptr_r  <= {FW{1'b0}};
      rd_ptr_r  <= {FW{1'b0}};
      count_r   <= {(FW+1){1'b0}};
      overrun_r <= 1'b0;
    end else begin
      wr_ptr_r <= push_ok_s ? wr_ptr_r + FW'(1) : wr_ptr_r;
      rd_ptr_r <= pop_s ? rd_ptr_r + FW'(1) : rd_ptr_r;
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + (FW+1)'(1);
        2'b01:   count_r <= count_r - (FW+1)'(1);
        default: count_r <= count_r;
      endcase
      if (push_s && !push_ok_s) begin
        overrun_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_delay_line_manager.sv
// Bench for delay_line_manager: random line contents and replacement words, checked each cycle
// against a word-level model of the line, the replacement queue and the report FIFO.
module tb_delay_line_manager;
  localparam int DW = 16, AW = 6, EW = 3, RD = 4, NMAX = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          n_reset, run, line_in, dut_out, test_mode, rep_valid, rep_ready;
  logic          rpt_replaced, rpt_valid, rpt_ready, rpt_overrun;
  logic [AW-1:0] no_nums, rep_addr, rpt_addr, word_addr;
  logic [7:0]    pulse_width, pulse_gap;
  logic [DW-1:0] rep_data, rpt_data;
  logic [EW-1:0] err_count;

  delay_line_manager #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PW_WIDTH(8), .GAP_WIDTH(8),
                       .REPORT_DEPTH(RD), .ERR_CNT_WIDTH(EW)) dut (
    .clk(clk), .n_reset(n_reset), .run(run), .in(line_in), .out(dut_out),
    .no_nums(no_nums), .pulse_width(pulse_width), .pulse_gap(pulse_gap), .test_mode(test_mode),
    .rep_addr(rep_addr), .rep_data(rep_data), .rep_valid(rep_valid), .rep_ready(rep_ready),
    .rpt_addr(rpt_addr), .rpt_data(rpt_data), .rpt_replaced(rpt_replaced), .rpt_valid(rpt_valid),
    .rpt_ready(rpt_ready), .rpt_overrun(rpt_overrun), .err_count(err_count), .word_addr(word_addr));

  // Model: slot position, line contents (word array), stuck-at-0 faults on the return path,
  // replacement queue, golden copies and the report queue.
  int            m_ctr, m_bit, m_word, m_err;
  bit            m_repl, m_ovr;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] line_m [NMAX];
  logic [DW-1:0] stuck  [NMAX];
  logic [DW-1:0] repl_m [NMAX];
  logic [DW-1:0] gold   [NMAX];
  bit            pend [NMAX];
  bit            gval [NMAX];
  logic [AW+DW:0] q [$];
  int n_tests, n_fail;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int n_words();
    return (no_nums == 0) ? NMAX : int'(no_nums);
  endfunction

  function automatic bit m_load();
    return run && n_reset && pulse_width != 0 &&
           m_ctr >= int'(pulse_gap) + int'(pulse_width) - 1 && m_bit == DW - 1;
  endfunction

  // Word returning from the line: in this loop model the line returns what is being written.
  function automatic logic [DW-1:0] ret_word();
    return (m_repl ? m_rdata : line_m[m_word]) & ~stuck[m_word];
  endfunction

  task automatic model_reset();
    m_ctr = 0; m_bit = 0; m_word = 0; m_repl = 1'b0; m_ovr = 1'b0; m_err = 0;
    for (int i = 0; i < NMAX; i++) begin pend[i] = 1'b0; gval[i] = 1'b0; end
    q.delete();
  endtask

  task automatic model_step();
    bit ld, mism;
    int w, nw;
    logic [DW-1:0] s;
    if (!n_reset || !run) begin model_reset(); return; end
    ld = m_load();
    if (rep_valid && !ld) begin
      repl_m[rep_addr] = rep_data; gold[rep_addr] = rep_data;
      pend[rep_addr] = 1'b1; gval[rep_addr] = 1'b1;
    end
    if (rpt_ready && q.size() > 0) void'(q.pop_front());
    if (pulse_width == 0) m_ctr = 0;
    else if (m_ctr >= int'(pulse_gap) + int'(pulse_width) - 1) begin
      m_ctr = 0;
      if (m_bit == DW - 1) begin
        w = m_word; s = ret_word();
        mism = test_mode && gval[w] && (s != gold[w]);
        if (mism || m_repl) begin
          if (q.size() < RD) q.push_back({AW'(w), s, m_repl});
          else m_ovr = 1'b1;
        end
        if (mism && m_err < (1 << EW) - 1) m_err++;
        line_m[w] = s;
        nw = (m_word >= n_words() - 1) ? 0 : m_word + 1;
        m_repl = pend[nw];
        if (pend[nw]) begin m_rdata = repl_m[nw]; pend[nw] = 1'b0; end
        m_bit = 0; m_word = nw;
      end else m_bit++;
    end else m_ctr++;
  endtask

  // One clock: drive the line return, check every output, advance DUT and model together.
  task automatic cyc();
    logic [DW-1:0] r;
    bit pulse, exp_out;
    r = ret_word();
    line_in = r[DW-1-m_bit];
    pulse = run && n_reset && pulse_width != 0 && m_ctr >= int'(pulse_gap);
    exp_out = pulse & (m_repl ? m_rdata[DW-1-m_bit] : r[DW-1-m_bit]);
    #1;
    chk("out", dut_out, exp_out);
    chk("word_addr", word_addr, m_word);
    chk("rep_ready", rep_ready, !m_load());
    chk("rpt_valid", rpt_valid, q.size() != 0);
    chk("rpt_overrun", rpt_overrun, m_ovr);
    chk("err_count", err_count, m_err);
    if (q.size() != 0) chk("rpt_entry", {rpt_addr, rpt_data, rpt_replaced}, q[0]);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic rep_write(int a, logic [DW-1:0] d);
    bit acc;
    rep_addr = AW'(a); rep_data = d; rep_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      acc = !m_load();
      cyc();
      if (acc) break;
    end
    rep_valid = 1'b0;
  endtask

  // Parameter changes are made at the start of a slot so no sample point is skipped or repeated.
  task automatic wait_ctr0();
    for (int k = 0; k < 20; k++) begin
      if (m_ctr == 0) return;
      cyc();
    end
    chk("wait_ctr0_timeout", m_ctr, 0);
  endtask

  initial begin
    int a;
    n_tests = 0; n_fail = 0;
    n_reset = 1'b0; run = 1'b0; line_in = 1'b0; test_mode = 1'b0; rep_valid = 1'b0;
    rpt_ready = 1'b1; rep_addr = '0; rep_data = '0;
    pulse_gap = 8'd2; pulse_width = 8'd2; no_nums = 6'd1;
    for (int i = 0; i < NMAX; i++) begin
      line_m[i] = DW'($urandom); stuck[i] = '0; repl_m[i] = '0; gold[i] = '0;
    end
    model_reset();
    @(posedge clk); #1;
    repeat (2) cyc();
    n_reset = 1'b1; run = 1'b1;

    // N=1: single word recirculates, word_addr stays 0
    repeat (2 * DW * 4) cyc();

    // N=8: replace word 3 and a random word written twice (last write wins)
    no_nums = 6'd8;
    rep_write(3, 16'hA5C3);
    a = $urandom_range(4, 7);
    rep_write(a, DW'($urandom));
    rep_write(a, DW'($urandom));
    repeat (2 * 8 * DW * 4) cyc();

    // Golden compare with a stuck-at-0 on bit 0 of word 2; counter saturates
    test_mode = 1'b1;
    stuck[2] = 16'h0001;
    rep_write(2, 16'h00FF);
    repeat (10 * 8 * DW * 4) cyc();

    // Reports back up without pops, then drain with random back-pressure
    rpt_ready = 1'b0;
    repeat (6 * 8 * DW * 4) cyc();
    repeat (2 * 8 * DW * 4) begin rpt_ready = 1'($urandom_range(0, 1)); cyc(); end
    rpt_ready = 1'b1;

    // Freeze with pulse_width 0, then resume
    repeat (37) cyc();
    wait_ctr0();
    pulse_width = 8'd0;
    repeat (50) cyc();
    pulse_width = 8'd2;
    repeat (8 * DW * 4) cyc();

    // Other slot timings, including pulse_width 1 (sample point at slot end)
    for (int k = 0; k < 3; k++) begin
      wait_ctr0();
      pulse_gap = 8'($urandom_range(0, 3));
      pulse_width = (k == 0) ? 8'd1 : 8'($urandom_range(1, 4));
      repeat (8 * DW * 8) cyc();
    end

    // Full 64-word address space, then shrink N mid-pass
    wait_ctr0();
    pulse_gap = 8'd1; pulse_width = 8'd1; no_nums = 6'd0;
    rep_write(63, DW'($urandom));
    repeat (NMAX * DW * 2 + 200) cyc();
    no_nums = 6'd4;
    repeat (600) cyc();

    // Synchronous clear via run
    wait_ctr0();
    pulse_gap = 8'd2; pulse_width = 8'd2;
    repeat (40) cyc();
    run = 1'b0;
    repeat (3) cyc();
    run = 1'b1;
    rep_write(1, DW'($urandom));
    repeat (300) cyc();

    // Asynchronous reset mid-word
    repeat (37) cyc();
    #3 n_reset = 1'b0;
    #1;
    model_reset();
    chk("rst_out", dut_out, 1'b0);
    chk("rst_word_addr", word_addr, 0);
    chk("rst_rpt_valid", rpt_valid, 1'b0);
    chk("rst_err_count", err_count, 0);
    chk("rst_overrun", rpt_overrun, 1'b0);
    @(posedge clk); #1;
    n_reset = 1'b1;
    repeat (600) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
